// File: rtl/sram_ws.sv
// ---------------------------------------------------------------------------
// sram_ws : single-port synchronous SRAM model with a programmable number of
//           access wait states and an asynchronous SRAM-style handshake.
//
// An access is framed by CS_n low. At the accepting edge the address, write
// data and operation are latched. The block then spends WAIT_STATES+1 cycles
// in WAIT. On the WAIT->DONE transition it either commits the write or loads
// DOUT. It then stays in DONE until CS_n returns high. Only one access is
// accepted per CS_n frame.
//
// Optional feature (macro SRAM_WS_PARITY_EN):
//   Each stored word carries an even-parity bit. A read that finds a parity
//   mismatch raises PERR together with RDY.
//   When the macro is not defined, PERR is tied to 0.
//
// Ports:
//   sysclk   in   1       sole clock, rising edge
//   sysrst   in   1       asynchronous active-high reset
//   A        in   ADDR_W  word address
//   CS_n     in   1       chip select, active low (frames one access)
//   OE_n     in   1       output enable / read request, active low
//   W_n      in   1       write request, active low (wins over OE_n)
//   DIN      in   DATA_W  write data
//   DOUT     out  DATA_W  registered read data
//   DOUT_EN  out  1       bus driver enable for DOUT
//   RDY      out  1       one-cycle access-complete pulse
//   PERR     out  1       parity error pulse, coincident with RDY
// ---------------------------------------------------------------------------
module sram_ws #(
  parameter int ADDR_W      = 11,
  parameter int DATA_W      = 8,
  parameter int WAIT_STATES = 2
) (
  input  logic              sysclk,
  input  logic              sysrst,
  input  logic [ADDR_W-1:0] A,
  input  logic              CS_n,
  input  logic              OE_n,
  input  logic              W_n,
  input  logic [DATA_W-1:0] DIN,
  output logic [DATA_W-1:0] DOUT,
  output logic              DOUT_EN,
  output logic              RDY,
  output logic              PERR
);

`ifdef SRAM_WS_PARITY_EN
  localparam int MEM_W = DATA_W + 1;

  // Even parity: the extra bit makes the total number of ones even.
  function automatic logic even_parity(input logic [DATA_W-1:0] d);
    return ^d;
  endfunction
`else
  localparam int MEM_W = DATA_W;
`endif

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_WAIT = 2'b01,
    ST_DONE = 2'b10
  } state_t;

  state_t            r_state;
  state_t            w_next;
  logic [3:0]        r_cnt;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_din;
  logic              r_wr;
  logic              r_armed;
  logic [DATA_W-1:0] r_dout;
  logic              r_rdy;
  logic              w_accept;
  logic              w_finish;
  logic [MEM_W-1:0]  w_rd_word;
  logic [MEM_W-1:0]  w_wr_word;

  logic [MEM_W-1:0]  r_mem [0:(2**ADDR_W)-1];

  assign w_rd_word = r_mem[r_addr];
`ifdef SRAM_WS_PARITY_EN
  assign w_wr_word = {even_parity(r_din), r_din};
`else
  assign w_wr_word = r_din;
`endif

  // Next-state logic. An access is accepted only once CS_n has been seen
  // high since the last access or reset (r_armed). An abort through CS_n
  // takes priority over completion.
  always_comb begin
    w_next   = r_state;
    w_accept = 1'b0;
    w_finish = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (!CS_n && (!W_n || !OE_n) && r_armed) begin
          w_next   = ST_WAIT;
          w_accept = 1'b1;
        end else begin
          w_next = ST_IDLE;
        end
      end
      ST_WAIT: begin
        if (CS_n) begin
          w_next = ST_IDLE;
        end else if (r_cnt == 4'd0) begin
          w_next   = ST_DONE;
          w_finish = 1'b1;
        end else begin
          w_next = ST_WAIT;
        end
      end
      ST_DONE: begin
        if (CS_n) begin
          w_next = ST_IDLE;
        end else begin
          w_next = ST_DONE;
        end
      end
      default: w_next = ST_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge sysclk or posedge sysrst) begin
    if (sysrst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Access latch, wait counter, frame arming, read data and ready pulse.
  always_ff @(posedge sysclk or posedge sysrst) begin
    if (sysrst) begin
      r_cnt   <= 4'd0;
      r_addr  <= '0;
      r_din   <= '0;
      r_wr    <= 1'b0;
      r_armed <= 1'b0;
      r_dout  <= '0;
      r_rdy   <= 1'b0;
    end else begin
      r_armed <= CS_n | (r_armed & ~w_accept);
      r_rdy   <= w_finish;
      if (w_accept) begin
        r_addr <= A;
        r_din  <= DIN;
        r_wr   <= ~W_n;
        r_cnt  <= 4'(WAIT_STATES);
      end else if (r_state == ST_WAIT && r_cnt != 4'd0) begin
        r_cnt <= r_cnt - 4'd1;
      end
      if (w_finish && !r_wr) begin
        r_dout <= w_rd_word[DATA_W-1:0];
      end
    end
  end

  // Storage array; contents are deliberately not reset.
  always_ff @(posedge sysclk) begin
    if (w_finish && r_wr) begin
      r_mem[r_addr] <= w_wr_word;
    end
  end

`ifdef SRAM_WS_PARITY_EN
  logic r_perr;

  // Parity check of the word read. A stored word with correct parity has an
  // even number of ones overall.
  always_ff @(posedge sysclk or posedge sysrst) begin
    if (sysrst) begin
      r_perr <= 1'b0;
    end else begin
      r_perr <= w_finish & ~r_wr & (^w_rd_word);
    end
  end

  assign PERR = r_perr;
`else
  assign PERR = 1'b0;
`endif

  assign DOUT    = r_dout;
  assign RDY     = r_rdy;
  // Bus enable follows CS_n/OE_n combinationally so the driver releases at once.
  assign DOUT_EN = (r_state == ST_DONE) & ~r_wr & ~CS_n & ~OE_n;

endmodule

// File: tb/tb_sram_ws.sv
// Bench for sram_ws. Three instances share one stimulus stream: wait states
// 2 (main, fully checked), 0 and 15 (checked for latency only).
// Latency convention: the start edge is edge 0, and RDY "at cycle N" means RDY
// is high just before edge N (sampled on the preceding falling edge).
module tb_sram_ws;
  localparam int AW = 11;
  localparam int DW = 8;

  logic          sysclk = 1'b0;
  logic          sysrst;
  logic [AW-1:0] A;
  logic          CS_n, OE_n, W_n;
  logic [DW-1:0] DIN;
  logic [DW-1:0] dout2, dout0, dout15;
  logic          en2, en0, en15, rdy2, rdy0, rdy15, perr2, perr0, perr15;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model: word-addressed memory plus the last value read out.
  logic [DW-1:0] m_mem [int];
  int            q_addr [$];
  logic [DW-1:0] m_dout;

  // Observations from the most recent access.
  int            o_lat2, o_lat0, o_lat15, o_rdy_cnt;
  logic [DW-1:0] o_dout;
  logic          o_en, o_perr;
  int            perr_seen = 0;

  always #5 sysclk = ~sysclk;

  sram_ws #(.ADDR_W(AW), .DATA_W(DW), .WAIT_STATES(2)) dut (
    .sysclk(sysclk), .sysrst(sysrst), .A(A), .CS_n(CS_n), .OE_n(OE_n), .W_n(W_n),
    .DIN(DIN), .DOUT(dout2), .DOUT_EN(en2), .RDY(rdy2), .PERR(perr2));
  sram_ws #(.ADDR_W(AW), .DATA_W(DW), .WAIT_STATES(0)) dut0 (
    .sysclk(sysclk), .sysrst(sysrst), .A(A), .CS_n(CS_n), .OE_n(OE_n), .W_n(W_n),
    .DIN(DIN), .DOUT(dout0), .DOUT_EN(en0), .RDY(rdy0), .PERR(perr0));
  sram_ws #(.ADDR_W(AW), .DATA_W(DW), .WAIT_STATES(15)) dut15 (
    .sysclk(sysclk), .sysrst(sysrst), .A(A), .CS_n(CS_n), .OE_n(OE_n), .W_n(W_n),
    .DIN(DIN), .DOUT(dout15), .DOUT_EN(en15), .RDY(rdy15), .PERR(perr15));

  always @(negedge sysclk) if (perr2 === 1'b1) perr_seen++;

  // Run one framed access; A/DIN are scrambled once it has started.
  task automatic access(input bit wr, input bit rd, input logic [AW-1:0] addr,
                        input logic [DW-1:0] data);
    @(negedge sysclk);
    A = addr; DIN = data; W_n = ~wr; OE_n = ~rd; CS_n = 1'b0;
    @(posedge sysclk);
    o_lat2 = -1; o_lat0 = -1; o_lat15 = -1; o_rdy_cnt = 0;
    o_dout = dout2; o_en = 1'b0; o_perr = 1'b0;
    for (int j = 1; j <= 20; j++) begin
      @(negedge sysclk);
      if (rdy2 === 1'b1) begin
        o_rdy_cnt++;
        if (o_lat2 < 0) begin
          o_lat2 = j; o_dout = dout2; o_en = en2; o_perr = perr2;
        end
      end
      if (rdy0 === 1'b1 && o_lat0 < 0) o_lat0 = j;
      if (rdy15 === 1'b1 && o_lat15 < 0) o_lat15 = j;
      A = AW'($urandom); DIN = DW'($urandom);
    end
  endtask

  task automatic end_frame();
    @(negedge sysclk);
    CS_n = 1'b1; W_n = 1'b1; OE_n = 1'b1;
    @(negedge sysclk);
  endtask

  task automatic note_write(input int addr, input logic [DW-1:0] data);
    if (!m_mem.exists(addr)) q_addr.push_back(addr);
    m_mem[addr] = data;
  endtask

  task automatic test_reset();
    sysrst = 1'b1; CS_n = 1'b1; W_n = 1'b1; OE_n = 1'b1; A = '0; DIN = '0;
    repeat (3) @(negedge sysclk);
    n_cmp++; if (dout2 !== 8'h00) begin n_err++; $display("FAIL reset_dout: got %h want 00", dout2); end
    n_cmp++; if (rdy2 !== 1'b0) begin n_err++; $display("FAIL reset_rdy: got %b want 0", rdy2); end
    n_cmp++; if (perr2 !== 1'b0) begin n_err++; $display("FAIL reset_perr: got %b want 0", perr2); end
    n_cmp++; if (en2 !== 1'b0) begin n_err++; $display("FAIL reset_en: got %b want 0", en2); end
    sysrst = 1'b0;
    m_dout = 8'h00;
    @(negedge sysclk);
  endtask

  task automatic test_directed();
    access(1'b1, 1'b0, 11'h123, 8'hA5);
    note_write(32'h123, 8'hA5);
    n_cmp++; if (o_lat2 !== 4) begin n_err++; $display("FAIL wr_latency: got %0d want 4", o_lat2); end
    n_cmp++; if (o_en !== 1'b0) begin n_err++; $display("FAIL wr_dout_en: got %b want 0", o_en); end
    end_frame();
    access(1'b0, 1'b1, 11'h123, 8'h00);
    m_dout = 8'hA5;
    n_cmp++; if (o_dout !== 8'hA5) begin n_err++; $display("FAIL rd_dout: got %h want a5", o_dout); end
    n_cmp++; if (o_en !== 1'b1) begin n_err++; $display("FAIL rd_dout_en: got %b want 1", o_en); end
    n_cmp++; if (o_lat2 !== 4) begin n_err++; $display("FAIL rd_latency: got %0d want 4", o_lat2); end
    n_cmp++; if (o_lat0 !== 2) begin n_err++; $display("FAIL latency_ws0: got %0d want 2", o_lat0); end
    n_cmp++; if (o_lat15 !== 17) begin n_err++; $display("FAIL latency_ws15: got %0d want 17", o_lat15); end
    n_cmp++; if (o_rdy_cnt !== 1) begin n_err++; $display("FAIL rdy_width: got %0d want 1", o_rdy_cnt); end
    // Still in DONE with CS_n low: releasing OE_n must drop the enable at once.
    @(negedge sysclk);
    OE_n = 1'b1;
    #1;
    n_cmp++; if (en2 !== 1'b0) begin n_err++; $display("FAIL oe_release_en: got %b want 0", en2); end
    end_frame();
  endtask

  task automatic test_random();
    for (int k = 0; k < 16; k++) begin
      bit            rd;
      int            addr;
      logic [DW-1:0] data;
      logic [DW-1:0] exp;
      rd = (q_addr.size() > 0) && ($urandom_range(0, 1) == 1);
      if (rd) addr = q_addr[$urandom_range(0, q_addr.size() - 1)];
      else addr = int'($urandom_range(0, (1 << AW) - 1));
      data = DW'($urandom);
      access(~rd, rd, AW'(addr), data);
      if (rd) begin
        m_dout = m_mem[addr];
      end else begin
        note_write(addr, data);
      end
      exp = m_dout;
      n_cmp++; if (o_dout !== exp) begin n_err++; $display("FAIL rand_dout[%0d]: got %h want %h", k, o_dout, exp); end
      n_cmp++; if (o_en !== rd) begin n_err++; $display("FAIL rand_en[%0d]: got %b want %b", k, o_en, rd); end
      n_cmp++; if (o_lat2 !== 4) begin n_err++; $display("FAIL rand_lat[%0d]: got %0d want 4", k, o_lat2); end
      n_cmp++; if (o_lat15 !== 17) begin n_err++; $display("FAIL rand_lat15[%0d]: got %0d want 17", k, o_lat15); end
      n_cmp++; if (o_perr !== 1'b0) begin n_err++; $display("FAIL rand_perr[%0d]: got %b want 0", k, o_perr); end
      end_frame();
    end
  endtask

  task automatic test_both_low();
    int addr;
    addr = 32'h2A7;
    access(1'b1, 1'b1, AW'(addr), 8'h77);
    n_cmp++; if (o_en !== 1'b0) begin n_err++; $display("FAIL both_low_en: got %b want 0", o_en); end
    n_cmp++; if (o_dout !== m_dout) begin n_err++; $display("FAIL both_low_dout: got %h want %h", o_dout, m_dout); end
    end_frame();
    note_write(addr, 8'h77);
    access(1'b0, 1'b1, AW'(addr), 8'h00);
    m_dout = 8'h77;
    n_cmp++; if (o_dout !== 8'h77) begin n_err++; $display("FAIL both_low_wrote: got %h want 77", o_dout); end
    end_frame();
  endtask

  task automatic test_abort();
    logic [DW-1:0] pv;
    int            rdy_hits;
    pv = 8'h3C ^ DW'($urandom_range(1, 255));
    access(1'b1, 1'b0, 11'h010, pv);
    note_write(32'h010, pv);
    end_frame();
    @(negedge sysclk);
    A = 11'h010; DIN = 8'h3C; W_n = 1'b0; OE_n = 1'b1; CS_n = 1'b0;
    @(posedge sysclk);
    @(negedge sysclk);
    @(negedge sysclk);
    CS_n = 1'b1; W_n = 1'b1;
    rdy_hits = 0;
    for (int j = 0; j < 6; j++) begin
      @(negedge sysclk);
      if (rdy2 === 1'b1) rdy_hits++;
    end
    n_cmp++; if (rdy_hits !== 0) begin n_err++; $display("FAIL abort_rdy: got %0d pulses want 0", rdy_hits); end
    n_cmp++; if (dout2 !== m_dout) begin n_err++; $display("FAIL abort_dout: got %h want %h", dout2, m_dout); end
    access(1'b0, 1'b1, 11'h010, 8'h00);
    m_dout = pv;
    n_cmp++; if (o_dout !== pv) begin n_err++; $display("FAIL abort_no_commit: got %h want %h", o_dout, pv); end
    end_frame();
  endtask

  task automatic test_reset_mid();
    for (int pass = 0; pass < 2; pass++) begin
      bit            wr;
      int            addr;
      int            rdy_hits;
      logic [DW-1:0] old;
      wr   = (pass == 0);
      addr = q_addr[$urandom_range(0, q_addr.size() - 1)];
      old  = m_mem[addr];
      @(negedge sysclk);
      A = AW'(addr); DIN = ~old; W_n = ~wr; OE_n = 1'b0; CS_n = 1'b0;
      @(posedge sysclk);
      @(negedge sysclk);
      @(negedge sysclk);
      sysrst = 1'b1;
      #1;
      m_dout = 8'h00;
      n_cmp++; if (dout2 !== 8'h00) begin n_err++; $display("FAIL rstmid_dout[%0d]: got %h want 00", pass, dout2); end
      n_cmp++; if (rdy2 !== 1'b0) begin n_err++; $display("FAIL rstmid_rdy[%0d]: got %b want 0", pass, rdy2); end
      n_cmp++; if (en2 !== 1'b0) begin n_err++; $display("FAIL rstmid_en[%0d]: got %b want 0", pass, en2); end
      @(negedge sysclk);
      sysrst = 1'b0;
      rdy_hits = 0;
      for (int j = 0; j < 8; j++) begin
        @(negedge sysclk);
        if (rdy2 === 1'b1) rdy_hits++;
      end
      n_cmp++; if (rdy_hits !== 0) begin n_err++; $display("FAIL rstmid_noreframe[%0d]: got %0d pulses want 0", pass, rdy_hits); end
      end_frame();
      access(1'b0, 1'b1, AW'(addr), 8'h00);
      m_dout = old;
      n_cmp++; if (o_dout !== old) begin n_err++; $display("FAIL rstmid_mem[%0d]: got %h want %h", pass, o_dout, old); end
      n_cmp++; if (o_lat2 !== 4) begin n_err++; $display("FAIL rstmid_lat[%0d]: got %0d want 4", pass, o_lat2); end
      end_frame();
    end
  endtask

  task automatic test_parity();
    int perr_exp;
`ifdef SRAM_WS_PARITY_EN
    int            addr;
    logic [DW:0]   word;
    logic [DW-1:0] bad;
    addr = q_addr[$urandom_range(0, q_addr.size() - 1)];
    @(negedge sysclk);
    word = dut.r_mem[addr];
    word[0] = ~word[0];
    dut.r_mem[addr] = word;
    bad = m_mem[addr] ^ 8'h01;
    m_mem[addr] = bad;
    access(1'b0, 1'b1, AW'(addr), 8'h00);
    m_dout = bad;
    n_cmp++; if (o_perr !== 1'b1) begin n_err++; $display("FAIL parity_perr: got %b want 1", o_perr); end
    n_cmp++; if (o_dout !== bad) begin n_err++; $display("FAIL parity_dout: got %h want %h", o_dout, bad); end
    end_frame();
    perr_exp = 1;
`else
    perr_exp = 0;
`endif
    n_cmp++; if (perr_seen !== perr_exp) begin n_err++; $display("FAIL perr_count: got %0d want %0d", perr_seen, perr_exp); end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_both_low();
    test_abort();
    test_reset_mid();
    test_parity();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/sram_ws.md
SRAM_WS -- requirements
Module: sram_ws

Interface
REQ-001 Parameter ADDR_W, default 11, address width (2^ADDR_W words).
REQ-002 Parameter DATA_W, default 8, data word width.
REQ-003 Parameter WAIT_STATES, default 2, access wait cycles, legal range 0..15.
REQ-004 Clocking SHALL be: one clock; reset is asynchronous and active-high.
REQ-005 sysclk  input  1  sole clock, all state on rising edge.
REQ-006 sysrst  input  1  asynchronous active-high reset.
REQ-007 A  input  ADDR_W  word address.
REQ-008 CS_n  input  1  chip select, active low; frames one access cycle.
REQ-009 OE_n  input  1  output enable / read request, active low.
REQ-010 W_n  input  1  write request, active low.
REQ-011 DIN  input  DATA_W  write data.
REQ-012 DOUT  output  DATA_W  registered read data.
REQ-013 DOUT_EN  output  1  high when DOUT is driven-valid (bus driver enable).
REQ-014 RDY  output  1  one-cycle pulse: access complete.
REQ-015 PERR  output  1  parity error pulse (see Configuration).

Function
REQ-016 FSM states IDLE, WAIT, DONE; reset state IDLE.
REQ-017 IDLE -> WAIT when CS_n=0 and (W_n=0 or OE_n=0) at a clock edge; latch A, DIN and op (write if W_n=0, else read); load counter with WAIT_STATES.
REQ-018 W_n=0 and OE_n=0 together at start: operation is write; read not performed.
REQ-019 WAIT: counter decrements each cycle; at 0 -> DONE. WAIT_STATES=0: WAIT lasts exactly one cycle.
REQ-020 On WAIT->DONE transition: write commits latched DIN to mem[latched A]; read loads DOUT from mem[latched A].
REQ-021 Latency start-edge to RDY-high: WAIT_STATES+2 cycles.
REQ-022 RDY high for exactly the first DONE cycle, low otherwise.
REQ-023 DONE held until CS_n=1; then -> IDLE; no new access accepted without CS_n returning high (one access per CS_n frame).
REQ-024 CS_n=1 during WAIT: abort -> IDLE; no write commit, DOUT unchanged, no RDY.
REQ-025 Changes on A, DIN, W_n, OE_n during WAIT/DONE ignored.
REQ-026 DOUT_EN = (state DONE) and last op read and CS_n=0 and OE_n=0; combinational on CS_n/OE_n.
REQ-027 DOUT holds last read value until next read completes.
REQ-028 Address wraps nothing: all 2^ADDR_W addresses valid; no out-of-range case.

Reset
REQ-029 sysrst=1 forces immediately: state IDLE, counter 0, DOUT 0, RDY 0, PERR 0, DOUT_EN 0.
REQ-030 Reset mid-access aborts it; pending write not committed.
REQ-031 Memory array contents not reset (undefined until written).
REQ-032 First access accepted at first edge after sysrst falls meeting REQ-017.

Configuration
REQ-033 Macro SRAM_WS_PARITY_EN defined: array stores DATA_W+1 bits, extra bit = even parity of DIN written at commit.
REQ-034 With macro: on read completion, recomputed parity of stored data compared to stored bit; mismatch -> PERR high same cycle as RDY, one cycle; DOUT still loaded.
REQ-035 Without macro: no parity storage, PERR constant 0.

Verification
REQ-036 Defaults; write A=0x123 DIN=0xA5, then read A=0x123 -> DOUT=0xA5, DOUT_EN=1, RDY at cycle 4 after start.
REQ-037 WAIT_STATES=0 and 15: RDY at cycle 2 and 17 after start respectively.
REQ-038 Start write A=0x010 DIN=0x3C, raise CS_n after 1 WAIT cycle -> no RDY; later read 0x010 returns prior value.
REQ-039 W_n=0 and OE_n=0 at start, DIN=0x77 -> write of 0x77, DOUT_EN stays 0, DOUT unchanged.
REQ-040 Assert sysrst during WAIT of a read -> DOUT=0, RDY=0, state IDLE immediately; CS_n held low afterwards starts no access until re-framed.
REQ-041 SRAM_WS_PARITY_EN defined: force-flip stored data bit via bench backdoor, read -> PERR=1 with RDY; undefined macro -> PERR=0 throughout.
